// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Holds the FSM state encoding and the decode of the (Q[0], q_m1) Booth pair.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then arithmetic
// right shift of {A, Q, q_m1}. Purely combinational, reused every CALC cycle.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] a_i,
  input  logic [WIDTH:0]   q_i,
  input  logic             qm1_i,
  input  logic [WIDTH+1:0] m_i,
  output logic [WIDTH+1:0] a_o,
  output logic [WIDTH:0]   q_o,
  output logic             qm1_o
);

  logic [WIDTH+1:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], qm1_i})
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      BOOTH_NOP: sum = a_i;
      default:   sum = a_i;
    endcase
  end

  // Old q_m1 falls off the bottom; A's sign bit is replicated at the top.
  assign {a_o, q_o, qm1_o} = {sum[WIDTH+1], sum, q_i};

endmodule

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle radix-2 Booth multiplier, one step per clock, signed/unsigned.
// Product appears WIDTH+1 cycles after accept and is held until consumed.
module booth_multiplier_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  mul_state_t         state_q, state_d;
  logic [WIDTH+1:0]   a_q, a_d;
  logic [WIDTH+1:0]   m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH+1:0]   a_step;
  logic [WIDTH:0]     q_step;
  logic               qm1_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_step),
    .q_o   (q_step),
    .qm1_o (qm1_step)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          // Q gets one extension bit and M two, so unsigned operands stay
          // positive and A never overflows.
          m_d     = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
          q_d     = {in_signed & in_b[WIDTH-1], in_b};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        a_d   = a_step;
        q_d   = q_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = DONE;
          prod_d  = {a_step[WIDTH-2:0], q_step};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_product = prod_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Randomised and directed bench for booth_multiplier_seq (WIDTH=32) against
// a cycle-timeline reference model using plain 64-bit arithmetic.
module tb_booth_multiplier_seq;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_signed = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] ax, bx;
    ax = s ? {{32{a[31]}}, a} : {32'b0, a};
    bx = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

  // Reference timeline: accept when idle, result LAT edges later, retire on out_ready.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_age  = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_age  <= 0;
      m_prod <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_pend <= ref_mul(in_a, in_b, in_signed);
      end
    end else if (!m_done) begin
      m_age <= m_age + 1;
      if (m_age + 1 == LAT) begin
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clock) begin
    chk("cyc_in_ready", 64'(in_ready), 64'(!m_busy));
    chk("cyc_out_valid", 64'(out_valid), 64'(m_done));
    chk("cyc_busy", 64'(busy), 64'(m_busy));
    if (m_done) chk("cyc_product", out_product, m_prod);
    if (!reset_n) chk("cyc_reset_product", out_product, 64'h0);
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    chk("start_ready", 64'(in_ready), 64'h1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom);
  endtask

  task automatic wait_result(output logic [63:0] prod, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    prod = out_product;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input int hold, output logic [63:0] prod, output int lat);
    out_ready = (hold == 0);
    start_op(a, b, s);
    wait_result(prod, lat);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock); #1;
      end
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 3));
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] prod, held;
    int lat, seen;

    // Model self-checks against hand-computed products.
    chk("model_u_ff", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
    chk("model_s_m1", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1), 64'h0000_0000_0000_0001);
    chk("model_s_min", ref_mul(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);
    chk("model_s_7m3", ref_mul(32'h7, 32'hFFFF_FFFD, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_u_7m3", ref_mul(32'h7, 32'hFFFF_FFFD, 1'b0), 64'h0000_0006_FFFF_FFEB);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_product", out_product, 64'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, prod, lat);
    chk("u_ff_prod", prod, 64'hFFFF_FFFE_0000_0001);
    chk("u_ff_latency", 64'(lat), 64'(LAT));
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, prod, lat);
    chk("s_m1_prod", prod, 64'h1);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, prod, lat);
    chk("s_min_prod", prod, 64'h4000_0000_0000_0000);
    do_op(32'h7, 32'hFFFF_FFFD, 1'b1, 0, prod, lat);
    chk("s_7m3_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(32'h7, 32'hFFFF_FFFD, 1'b0, 0, prod, lat);
    chk("u_7m3_prod", prod, 64'h0000_0006_FFFF_FFEB);
    chk("post_op_ready", 64'(in_ready), 64'h1);

    // Backpressure: DONE held for 20 cycles.
    out_ready = 1'b0;
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_result(held, lat);
    chk("bp_prod", held, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
    repeat (20) begin
      @(posedge clock); #1;
      chk("bp_out_valid", 64'(out_valid), 64'h1);
      chk("bp_product_stable", out_product, held);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    chk("bp_release_valid", 64'(out_valid), 64'h0);

    // in_valid during CALC must be dropped.
    start_op(32'h7, 32'hFFFF_FFFD, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    in_a = 32'hDEAD_BEEF; in_b = 32'h1111_2222; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_result(prod, lat);
    chk("ign_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("ign_latency", 64'(lat), 64'(LAT - 6));
    seen = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    chk("ign_no_second", 64'(seen), 64'h0);

    // Reset mid-CALC aborts the operation.
    start_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'h0);
    chk("abort_in_ready", 64'(in_ready), 64'h1);
    chk("abort_product", out_product, 64'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_op(32'd3, 32'd5, 1'b0, 0, prod, lat);
    chk("after_abort_prod", prod, 64'd15);
    chk("after_abort_latency", 64'(lat), 64'(LAT));

    // Randomised operands, modes, stalls and idle gaps.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      bit s;
      int hold;
      a = pick_operand();
      b = pick_operand();
      s = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
      do_op(a, b, s, hold, prod, lat);
      chk("rand_prod", prod, ref_mul(a, b, s));
      chk("rand_latency", 64'(lat), 64'(LAT));
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
